inst_fetch_unit: RTL and testbench

- Producer side of the instruction buffer FIFO.
- Holds the fetch PC, issues one outstanding read at a time to the ICache, and captures the 1- or 2-word response.
- Pushes that response into the instruction buffer as a 1- or 2-entry write, honouring the buffer's full flag.
- Sits between ICache and the instruction buffer. Flush/redirect from the backend discards in-flight work and restarts at a new PC.

---
 rtl/inst_fetch_unit_pkg.sv | 18 +
 rtl/inst_fetch_pc_gen.sv | 31 +++
 rtl/inst_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, reset PC, NOP encoding and fetch-state encoding for the instruction fetch unit.
// INST_FETCH_ADEL_EN enables misaligned-PC (address error) reporting instead of alignment masking.
package inst_fetch_unit_pkg;

    localparam int unsigned IFU_ADDR_W   = 32;
    localparam int unsigned IFU_INST_W   = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_DROP,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_pc_gen.sv
// Next fetch PC select: flush target, +4/+8 advance after a push, or hold.
// Without INST_FETCH_ADEL_EN the flush target is forced word-aligned.
module inst_fetch_pc_gen #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              advance_i,
    input  logic              dual_i,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [ADDR_W-1:0] flush_target;

`ifdef INST_FETCH_ADEL_EN
    assign flush_target = flush_pc_i;
`else
    assign flush_target = {flush_pc_i[ADDR_W-1:2], 2'b00};
`endif

    always_comb begin
        pc_next_o = pc_i;
        if (flush_i) begin
            pc_next_o = flush_target;
        end else if (advance_i) begin
            pc_next_o = pc_i + (dual_i ? ADDR_W'(8) : ADDR_W'(4));
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one outstanding ICache read, 1/2-word push into the instruction buffer.
// INST_FETCH_ADEL_EN adds buf_adel_o and a HALT state for misaligned fetch PCs.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IFU_ADDR_W,
    parameter int unsigned       INST_W   = IFU_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              icache_req_o,
    output logic [ADDR_W-1:0] icache_req_addr_o,
    input  logic              icache_req_ready_i,
    input  logic              icache_resp_valid_i,
    input  logic [INST_W-1:0] icache_resp_inst1_i,
    input  logic [INST_W-1:0] icache_resp_inst2_i,
    input  logic              icache_resp_dual_i,
    input  logic              buffer_full_i,
    output logic [INST_W-1:0] buf_inst1_o,
    output logic [INST_W-1:0] buf_inst2_o,
    output logic [ADDR_W-1:0] buf_inst1_addr_o,
    output logic [ADDR_W-1:0] buf_inst2_addr_o,
    output logic              buf_inst1_valid_o,
    output logic              buf_inst2_valid_o
`ifdef INST_FETCH_ADEL_EN
    ,
    output logic              buf_adel_o
`endif
);

`ifdef INST_FETCH_ADEL_EN
    localparam logic [ADDR_W-1:0] RESET_PC_EFF = RESET_PC;
`else
    localparam logic [ADDR_W-1:0] RESET_PC_EFF = {RESET_PC[ADDR_W-1:2], 2'b00};
`endif

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst1_q, inst1_d;
    logic [INST_W-1:0] inst2_q, inst2_d;
    logic              dual_q, dual_d;
    logic              advance;
    logic              push;
    logic              req_ok;

`ifdef INST_FETCH_ADEL_EN
    logic adel_q, adel_d;
    logic misaligned;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign req_ok     = (state_q == S_REQ) && !flush_i && !misaligned;
    assign buf_adel_o = adel_q && push;
`else
    assign req_ok     = (state_q == S_REQ) && !flush_i;
`endif

    // Reset gating keeps the request low while rst is held even though state already reads REQ.
    assign icache_req_o      = req_ok && rst;
    assign icache_req_addr_o = pc_q;

    assign push              = (state_q == S_PUSH) && !buffer_full_i && !flush_i;
    assign buf_inst1_valid_o = push;
    assign buf_inst2_valid_o = push && dual_q;
    assign buf_inst1_o       = inst1_q;
    assign buf_inst2_o       = inst2_q;
    assign buf_inst1_addr_o  = pc_q;
    assign buf_inst2_addr_o  = pc_q + ADDR_W'(4);

    inst_fetch_pc_gen #(
        .ADDR_W (ADDR_W)
    ) u_pc_gen (
        .pc_i       (pc_q),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .advance_i  (advance),
        .dual_i     (dual_q),
        .pc_next_o  (pc_d)
    );

    always_comb begin
        state_d = state_q;
        inst1_d = inst1_q;
        inst2_d = inst2_q;
        dual_d  = dual_q;
        advance = 1'b0;
`ifdef INST_FETCH_ADEL_EN
        adel_d  = adel_q;
`endif
        if (flush_i) begin
            // A flush while a read is still in flight must swallow its late response.
            case (state_q)
                S_WAIT, S_DROP: state_d = icache_resp_valid_i ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
`ifdef INST_FETCH_ADEL_EN
                    if (misaligned) begin
                        state_d = S_PUSH;
                        inst1_d = NOP_INST;
                        inst2_d = NOP_INST;
                        dual_d  = 1'b0;
                        adel_d  = 1'b1;
                    end else
`endif
                    if (req_ok && icache_req_ready_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (icache_resp_valid_i) begin
                        state_d = S_PUSH;
                        inst1_d = icache_resp_inst1_i;
                        inst2_d = icache_resp_inst2_i;
                        dual_d  = icache_resp_dual_i && !pc_q[2];
`ifdef INST_FETCH_ADEL_EN
                        adel_d  = 1'b0;
`endif
                    end
                end
                S_PUSH: begin
                    if (!buffer_full_i) begin
                        advance = 1'b1;
`ifdef INST_FETCH_ADEL_EN
                        state_d = adel_q ? S_HALT : S_REQ;
`else
                        state_d = S_REQ;
`endif
                    end
                end
                S_DROP: begin
                    if (icache_resp_valid_i) begin
                        state_d = S_REQ;
                    end
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC_EFF;
            inst1_q <= '0;
            inst2_q <= '0;
            dual_q  <= 1'b0;
`ifdef INST_FETCH_ADEL_EN
            adel_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst1_q <= inst1_d;
            inst2_q <= inst2_d;
            dual_q  <= dual_d;
`ifdef INST_FETCH_ADEL_EN
            adel_q  <= adel_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit: an ICache/buffer model queues expected
// requests and pushes; a negedge monitor pops and compares whenever the DUT presents one.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        icache_req_o;
    logic [31:0] icache_req_addr_o;
    logic        icache_req_ready_i = 1'b0;
    logic        icache_resp_valid_i = 1'b0;
    logic [31:0] icache_resp_inst1_i = '0;
    logic [31:0] icache_resp_inst2_i = '0;
    logic        icache_resp_dual_i = 1'b0;
    logic        buffer_full_i = 1'b0;
    logic [31:0] buf_inst1_o, buf_inst2_o, buf_inst1_addr_o, buf_inst2_addr_o;
    logic        buf_inst1_valid_o, buf_inst2_valid_o;
`ifdef INST_FETCH_ADEL_EN
    logic        buf_adel_o;
`endif

    inst_fetch_unit #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush_i),
        .flush_pc_i          (flush_pc_i),
        .icache_req_o        (icache_req_o),
        .icache_req_addr_o   (icache_req_addr_o),
        .icache_req_ready_i  (icache_req_ready_i),
        .icache_resp_valid_i (icache_resp_valid_i),
        .icache_resp_inst1_i (icache_resp_inst1_i),
        .icache_resp_inst2_i (icache_resp_inst2_i),
        .icache_resp_dual_i  (icache_resp_dual_i),
        .buffer_full_i       (buffer_full_i),
        .buf_inst1_o         (buf_inst1_o),
        .buf_inst2_o         (buf_inst2_o),
        .buf_inst1_addr_o    (buf_inst1_addr_o),
        .buf_inst2_addr_o    (buf_inst2_addr_o),
        .buf_inst1_valid_o   (buf_inst1_valid_o),
        .buf_inst2_valid_o   (buf_inst2_valid_o)
`ifdef INST_FETCH_ADEL_EN
        ,
        .buf_adel_o          (buf_adel_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        dual;
    } push_t;

    push_t       push_q[$];
    logic [31:0] req_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_push = 0;
    bit          run_checks = 1'b0;

    // ICache model state and the architectural next-fetch address.
    bit          outstanding = 1'b0;
    bit          disc = 1'b0;
    int          lat = 0;
    logic [31:0] cur_addr = '0;
    logic [31:0] model_pc = RST_PC;

    push_t       mon_e;
    logic [31:0] mon_a;

    always @(negedge clk) begin
        if (run_checks) begin
            if (flush_i) begin
                n_cmp++;
                if (icache_req_o || buf_inst1_valid_o || buf_inst2_valid_o) begin
                    n_err++;
                    $display("FAIL flush_quiet: req=%b v1=%b v2=%b, required 0 0 0",
                             icache_req_o, buf_inst1_valid_o, buf_inst2_valid_o);
                end
            end
            if (icache_req_o) begin
                n_cmp++;
                if (outstanding) begin
                    n_err++;
                    $display("FAIL one_outstanding: req=1 while a read is in flight, required req=0");
                end
            end
            if (icache_req_o && icache_req_ready_i) begin
                n_cmp++;
                if (req_q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_addr: got unexpected request addr=%08h, required none", icache_req_addr_o);
                end else begin
                    mon_a = req_q.pop_front();
                    if (icache_req_addr_o !== mon_a) begin
                        n_err++;
                        $display("FAIL req_addr: got %08h, required %08h", icache_req_addr_o, mon_a);
                    end
                end
            end
            if (buf_inst2_valid_o && !buf_inst1_valid_o) begin
                n_cmp++;
                n_err++;
                $display("FAIL v2_without_v1: v1=0 v2=1, required v2=0");
            end
            if (buf_inst1_valid_o) begin
                n_cmp++;
                n_push++;
                if (push_q.size() == 0) begin
                    n_err++;
                    $display("FAIL push: got unexpected push addr=%08h inst=%08h, required none",
                             buf_inst1_addr_o, buf_inst1_o);
                end else begin
                    mon_e = push_q.pop_front();
                    if (buf_inst1_addr_o !== mon_e.addr || buf_inst1_o !== mon_e.i1 ||
                        buf_inst2_valid_o !== mon_e.dual ||
                        (mon_e.dual && (buf_inst2_o !== mon_e.i2 || buf_inst2_addr_o !== mon_e.addr + 32'd4))) begin
                        n_err++;
                        $display("FAIL push: got a1=%08h i1=%08h v2=%b a2=%08h i2=%08h, required a1=%08h i1=%08h v2=%b a2=%08h i2=%08h",
                                 buf_inst1_addr_o, buf_inst1_o, buf_inst2_valid_o, buf_inst2_addr_o, buf_inst2_o,
                                 mon_e.addr, mon_e.i1, mon_e.dual, mon_e.addr + 32'd4, mon_e.i2);
                    end
                end
            end
        end
    end

    task automatic drive_cycle(input int p_flush, input int p_full, input int p_ready, input int p_dual);
        bit eff;
        int r;
        @(posedge clk);
        #1;
        icache_resp_valid_i = 1'b0;
        flush_i             = 1'b0;
        icache_req_ready_i  = ($urandom_range(99) < p_ready);
        buffer_full_i       = ($urandom_range(99) < p_full);
        if (outstanding) begin
            if (lat == 0) begin
                icache_resp_valid_i = 1'b1;
                icache_resp_inst1_i = $urandom;
                icache_resp_inst2_i = $urandom;
                icache_resp_dual_i  = ($urandom_range(99) < p_dual);
                outstanding         = 1'b0;
            end else begin
                lat--;
            end
        end
        if ($urandom_range(99) < p_flush) begin
            flush_i = 1'b1;
            r = $urandom_range(3);
            flush_pc_i = (r == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        end
        if (icache_resp_valid_i && !flush_i && !disc) begin
            eff = icache_resp_dual_i && (cur_addr % 8 == 0);
            push_q.push_back('{cur_addr, icache_resp_inst1_i, icache_resp_inst2_i, eff});
            model_pc = cur_addr + (eff ? 32'd8 : 32'd4);
            req_q.push_back(model_pc);
        end
        if (icache_resp_valid_i) disc = 1'b0;
        if (flush_i) begin
            push_q.delete();
            req_q.delete();
            model_pc = flush_pc_i - (flush_pc_i % 4);
            req_q.push_back(model_pc);
            if (outstanding) disc = 1'b1;
        end
        @(negedge clk);
        #1;
        if (icache_req_o && icache_req_ready_i) begin
            outstanding = 1'b1;
            disc        = 1'b0;
            cur_addr    = model_pc;
            lat         = $urandom_range(3);
            n_acc++;
        end
    endtask

    initial begin
        icache_req_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (icache_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req: got %b, required 0", icache_req_o);
        end
        n_cmp++;
        if (buf_inst1_valid_o !== 1'b0 || buf_inst2_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got v1=%b v2=%b, required 0 0", buf_inst1_valid_o, buf_inst2_valid_o);
        end
        req_q.push_back(RST_PC);
        @(posedge clk);
        #1;
        icache_req_ready_i = 1'b0;
        rst = 1'b1;
        run_checks = 1'b1;

        repeat (40)   drive_cycle(0, 0, 100, 100);
        repeat (400)  drive_cycle(0, 40, 60, 50);
        repeat (300)  drive_cycle(0, 85, 80, 70);
        repeat (4000) drive_cycle(6, 30, 70, 60);
        repeat (300)  drive_cycle(15, 50, 50, 50);
        repeat (40)   drive_cycle(0, 0, 100, 50);

        n_cmp++;
        if (push_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pushes still owed, required 0", push_q.size());
        end
        n_cmp++;
        if (n_acc < 100 || n_push < 100) begin
            n_err++;
            $display("FAIL progress: got %0d requests %0d pushes, required at least 100 each", n_acc, n_push);
        end
        run_checks = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
